// File: rtl/dict_builder_if.sv
// Command, byte-stream and memory-write signals of the dictionary loader.
// The master modport is the builder's view; the slave modport is the host/memory side.
interface dict_builder_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
) ();
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_mode;
    logic [7:0]     cmd_len;
    logic [DSZ-1:0] cmd_op;
    logic           in_valid;
    logic           in_ready;
    logic [DSZ-1:0] in_data;
    logic           in_last;
    logic           mem_we;
    logic [ASZ-1:0] mem_ai;
    logic [DSZ-1:0] mem_vi;

    modport master (
        input  cmd_valid, cmd_mode, cmd_len, cmd_op,
        input  in_valid, in_data, in_last,
        output cmd_ready, in_ready,
        output mem_we, mem_ai, mem_vi
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_len, cmd_op,
        output in_valid, in_data, in_last,
        input  cmd_ready, in_ready,
        input  mem_we, mem_ai, mem_vi
    );
endinterface

// File: rtl/dict_builder.sv
// Dictionary / TIB loader: an FSM that writes linked word headers at 'here'
// (link, length, name, opcode) or streams a zero-terminated line into the TIB.
module dict_builder #(
    parameter int TIB      = 'h0,
    parameter int DICT     = 'h100,
    parameter int DICT_END = 'h1FFFF,
    parameter int ASZ      = 17,
    parameter int DSZ      = 8,
    parameter int LINK_B   = 2,
    parameter int NMAX     = 31
) (
    input  logic            clk,
    input  logic            rst,
    dict_builder_if.master  bus,
    output logic [ASZ-1:0]  ctx,
    output logic [ASZ-1:0]  here,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [ASZ-1:0] CTX_NULL = ASZ'((64'd1 << (8 * LINK_B)) - 64'd1);
    localparam logic [ASZ-1:0] HERE_RST = ASZ'(DICT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINK,
        S_LEN,
        S_NAME,
        S_OP,
        S_TIB,
        S_TERM
    } state_t;

    state_t          state_q, state_d;
    logic [ASZ-1:0]  cnt_q, cnt_d;
    logic [7:0]      len_q, len_d;
    logic [DSZ-1:0]  op_q, op_d;
    logic [ASZ-1:0]  ctx_q, ctx_d;
    logic [ASZ-1:0]  here_q, here_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            cmd_ready;
    logic            in_ready;
    logic            mem_we;
    logic [ASZ-1:0]  mem_ai;
    logic [DSZ-1:0]  mem_vi;

    logic [ASZ-1:0]  name_base;
    logic [ASZ-1:0]  pfa;
    logic [ASZ-1:0]  tib_addr;
    logic [31:0]     word_end;
    logic            word_bad;
    logic            tib_over;
    logic            term_over;

    assign name_base = here_q + ASZ'(LINK_B) + ASZ'(1);
    assign pfa       = name_base + ASZ'(len_q);
    assign tib_addr  = ASZ'(TIB) + cnt_q;

    // Fit check uses wide arithmetic so a header near the top of memory cannot wrap past DICT_END.
    assign word_end  = 32'(here_q) + 32'(LINK_B) + 32'(bus.cmd_len) + 32'd1;
    assign word_bad  = (bus.cmd_len == 8'd0) || (32'(bus.cmd_len) > 32'(NMAX))
                       || (word_end > 32'(DICT_END));
    assign tib_over  = (32'(TIB) + 32'(cnt_q)) >= 32'(DICT);
    assign term_over = (32'(TIB) + 32'(cnt_q) + 32'd1) >= 32'(DICT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        op_d      = op_q;
        ctx_d     = ctx_q;
        here_d    = here_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_ai    = '0;
        mem_vi    = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    cnt_d = '0;
                    if (bus.cmd_mode) begin
                        state_d = S_TIB;
                    end else if (word_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = bus.cmd_len;
                        op_d    = bus.cmd_op;
                        state_d = S_LINK;
                    end
                end
            end

            S_LINK: begin
                mem_we = 1'b1;
                mem_ai = here_q + cnt_q;
                mem_vi = DSZ'(ctx_q >> (8 * cnt_q));
                if (cnt_q == ASZ'(LINK_B - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LEN;
                end else begin
                    cnt_d = cnt_q + ASZ'(1);
                end
            end

            S_LEN: begin
                mem_we  = 1'b1;
                mem_ai  = here_q + ASZ'(LINK_B);
                mem_vi  = DSZ'(len_q);
                state_d = S_NAME;
            end

            S_NAME: begin
                in_ready = 1'b1;
                mem_ai   = name_base + cnt_q;
                mem_vi   = bus.in_data;
                if (bus.in_valid) begin
                    mem_we = 1'b1;
                    if (cnt_q == ASZ'(len_q) - ASZ'(1)) begin
                        state_d = S_OP;
                    end else begin
                        cnt_d = cnt_q + ASZ'(1);
                    end
                end
            end

            S_OP: begin
                mem_we  = 1'b1;
                mem_ai  = pfa;
                mem_vi  = op_q;
                ctx_d   = here_q;
                here_d  = pfa + ASZ'(1);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            S_TIB: begin
                in_ready = 1'b1;
                mem_ai   = tib_addr;
                mem_vi   = bus.in_data;
                if (bus.in_valid) begin
                    // A byte that would land on the dictionary aborts the load unwritten.
                    if (tib_over) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        mem_we = 1'b1;
                        if (bus.in_last) begin
                            state_d = S_TERM;
                        end else begin
                            cnt_d = cnt_q + ASZ'(1);
                        end
                    end
                end
            end

            S_TERM: begin
                state_d = S_IDLE;
                if (term_over) begin
                    err_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    mem_ai = tib_addr + ASZ'(1);
                    mem_vi = '0;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            ctx_q   <= CTX_NULL;
            here_q  <= HERE_RST;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
            ctx_q   <= ctx_d;
            here_q  <= here_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_ai    = mem_ai;
    assign bus.mem_vi    = mem_vi;

    assign ctx  = ctx_q;
    assign here = here_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_dict_builder.sv
// Directed bench: two loaders (full dictionary and DICT_END=0x10A) see the same
// command stream; writes are captured into byte models and checked against hand-computed images.
module tb_dict_builder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       cmd_valid = 1'b0;
    logic       cmd_mode  = 1'b0;
    logic [7:0] cmd_len   = 8'd0;
    logic [7:0] cmd_op    = 8'd0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic       in_last   = 1'b0;

    logic [16:0] ctx_a, here_a, ctx_b, here_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    dict_builder_if #(.ASZ(17), .DSZ(8)) ifa ();
    dict_builder_if #(.ASZ(17), .DSZ(8)) ifb ();

    assign ifa.cmd_valid = cmd_valid;
    assign ifa.cmd_mode  = cmd_mode;
    assign ifa.cmd_len   = cmd_len;
    assign ifa.cmd_op    = cmd_op;
    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_last   = in_last;
    assign ifb.cmd_valid = cmd_valid;
    assign ifb.cmd_mode  = cmd_mode;
    assign ifb.cmd_len   = cmd_len;
    assign ifb.cmd_op    = cmd_op;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_last   = in_last;

    dict_builder u_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa.master),
        .ctx  (ctx_a),
        .here (here_a),
        .busy (busy_a),
        .done (done_a),
        .err  (err_a)
    );

    dict_builder #(.DICT_END('h10A)) u_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifb.master),
        .ctx  (ctx_b),
        .here (here_b),
        .busy (busy_b),
        .done (done_b),
        .err  (err_b)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_a [0:511];
    logic [7:0] mem_b [0:511];
    int wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0, er_a = 0, er_b = 0, both_n = 0;

    always @(negedge clk) begin
        if (ifa.mem_we) begin
            mem_a[ifa.mem_ai[8:0]] <= ifa.mem_vi;
            wr_a <= wr_a + 1;
        end
        if (ifb.mem_we) begin
            mem_b[ifb.mem_ai[8:0]] <= ifb.mem_vi;
            wr_b <= wr_b + 1;
        end
        if (done_a) dn_a <= dn_a + 1;
        if (done_b) dn_b <= dn_b + 1;
        if (err_a)  er_a <= er_a + 1;
        if (err_b)  er_b <= er_b + 1;
        if ((done_a && err_a) || (done_b && err_b)) both_n <= both_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Called at posedge+1; holds cmd_valid until loader A has taken it.
    task automatic issue(input logic mode, input logic [7:0] len, input logic [7:0] op);
        int n;
        logic rdy;
        n = 0;
        cmd_mode  = mode;
        cmd_len   = len;
        cmd_op    = op;
        cmd_valid = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            rdy = ifa.cmd_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_taken", 32'(n < 20), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        logic rdy;
        n = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            rdy = ifa.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("beat_taken", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 30 && busy_a) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("idle", 32'(busy_a), 32'd0);
    endtask

    logic [7:0] exp_dup  [7] = '{8'hFF, 8'hFF, 8'h03, 8'h64, 8'h75, 8'h70, 8'h01};
    logic [7:0] exp_drop [8] = '{8'h00, 8'h01, 8'h04, 8'h64, 8'h72, 8'h6F, 8'h70, 8'h02};
    logic [7:0] exp_tib  [8] = '{8'h20, 8'h20, 8'h64, 8'h75, 8'h70, 8'h20, 8'h2B, 8'h00};

    int w0a, w0b, d0a, d0b, e0a, e0b;

    task automatic snap();
        w0a = wr_a; w0b = wr_b; d0a = dn_a; d0b = dn_b; e0a = er_a; e0b = er_b;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctx",       32'(ctx_a), 32'hFFFF);
        chk("rst_here",      32'(here_a), 32'h100);
        chk("rst_busy",      32'(busy_a), 32'd0);
        chk("rst_mem_we",    32'(ifa.mem_we), 32'd0);
        chk("rst_mem_ai",    32'(ifa.mem_ai), 32'd0);
        chk("rst_cmd_ready", 32'(ifa.cmd_ready), 32'd1);
        chk("rst_in_ready",  32'(ifa.in_ready), 32'd0);
        chk("rst_done_err",  32'({done_a, err_a}), 32'd0);
        @(posedge clk); #1;

        // "dup" op 0x01: fits in both loaders
        snap();
        issue(1'b0, 8'd3, 8'h01);
        send_byte(8'h64, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'h70, 1'b0);
        wait_idle();
        for (int i = 0; i < 7; i++)
            chk($sformatf("dup_m%0h", 'h100 + i), 32'(mem_a['h100 + i]), 32'(exp_dup[i]));
        chk("dup_writes",  32'(wr_a - w0a), 32'd7);
        chk("dup_done",    32'(dn_a - d0a), 32'd1);
        chk("dup_ctx",     32'(ctx_a), 32'h100);
        chk("dup_here",    32'(here_a), 32'h107);
        chk("dup_b_here",  32'(here_b), 32'h107);

        // "drop" op 0x02 with a two-cycle gap mid-name; B overflows DICT_END
        snap();
        issue(1'b0, 8'd4, 8'h02);
        send_byte(8'h64, 1'b0);
        send_byte(8'h72, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h6F, 1'b0);
        send_byte(8'h70, 1'b0);
        wait_idle();
        for (int i = 0; i < 8; i++)
            chk($sformatf("drop_m%0h", 'h107 + i), 32'(mem_a['h107 + i]), 32'(exp_drop[i]));
        chk("drop_writes",   32'(wr_a - w0a), 32'd8);
        chk("drop_done",     32'(dn_a - d0a), 32'd1);
        chk("drop_ctx",      32'(ctx_a), 32'h107);
        chk("drop_here",     32'(here_a), 32'h10F);
        chk("drop_b_err",    32'(er_b - e0b), 32'd1);
        chk("drop_b_writes", 32'(wr_b - w0b), 32'd0);
        chk("drop_b_here",   32'(here_b), 32'h107);

        // Length limits: 0 and NMAX+1 are rejected without writes
        snap();
        issue(1'b0, 8'd0, 8'h09);
        wait_idle();
        chk("len0_err",    32'(er_a - e0a), 32'd1);
        chk("len0_writes", 32'(wr_a - w0a), 32'd0);
        snap();
        issue(1'b0, 8'd32, 8'h09);
        wait_idle();
        chk("len32_err",    32'(er_a - e0a), 32'd1);
        chk("len32_done",   32'(dn_a - d0a), 32'd0);
        chk("len32_writes", 32'(wr_a - w0a), 32'd0);
        chk("len_ctx",      32'(ctx_a), 32'h107);
        chk("len_here",     32'(here_a), 32'h10F);

        // "swap": B (here=0x107, end 0x10A) rejects; A is reset mid-name
        snap();
        issue(1'b0, 8'd4, 8'h03);
        send_byte(8'h73, 1'b0);
        send_byte(8'h77, 1'b0);
        chk("swap_b_err",    32'(er_b - e0b), 32'd1);
        chk("swap_b_writes", 32'(wr_b - w0b), 32'd0);
        chk("swap_a_busy",   32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",     32'(busy_a), 32'd0);
        chk("mid_rst_ctx",      32'(ctx_a), 32'hFFFF);
        chk("mid_rst_here",     32'(here_a), 32'h100);
        chk("mid_rst_in_ready", 32'(ifa.in_ready), 32'd0);
        chk("swap_partial_m10f", 32'(mem_a['h10F]), 32'h07);
        chk("swap_partial_m113", 32'(mem_a['h113]), 32'h77);
        @(posedge clk); #1;

        // TIB load "  dup +" in both loaders
        snap();
        issue(1'b1, 8'd0, 8'h00);
        for (int i = 0; i < 7; i++)
            send_byte(exp_tib[i], i == 6);
        wait_idle();
        for (int i = 0; i < 8; i++)
            chk($sformatf("tib_m%0h", i), 32'(mem_a[i]), 32'(exp_tib[i]));
        chk("tib_writes",   32'(wr_a - w0a), 32'd8);
        chk("tib_done",     32'(dn_a - d0a), 32'd1);
        chk("tib_b_m07",    32'(mem_b[7]), 32'h00);
        chk("tib_b_m06",    32'(mem_b[6]), 32'h2B);
        chk("tib_b_done",   32'(dn_b - d0b), 32'd1);
        chk("tib_here",     32'(here_a), 32'h100);

        chk("done_err_excl", 32'(both_n), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
